// File: rtl/pl_pkg.sv
// ---------------------------------------------------------------------------
// pl_pkg -- shared definitions for the program loader.
//
// Holds the byte/word widths, the loader FSM state encoding and a helper that
// tells whether a state is one in which the loader takes a byte from the
// receive stream.
// ---------------------------------------------------------------------------
package pl_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int ST_W   = 4;

  typedef logic [ST_W-1:0] state_t;

  // State encoding kept as plain constants so older tools and waveform
  // decoders that expect fixed values keep working.
  localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [ST_W-1:0] ST_HDR_HI = 4'd1;
  localparam logic [ST_W-1:0] ST_HDR_LO = 4'd2;
  localparam logic [ST_W-1:0] ST_DAT_HI = 4'd3;
  localparam logic [ST_W-1:0] ST_DAT_LO = 4'd4;
  localparam logic [ST_W-1:0] ST_WRITE  = 4'd5;
  localparam logic [ST_W-1:0] ST_HOLD   = 4'd6;
  localparam logic [ST_W-1:0] ST_FIN    = 4'd7;
  localparam logic [ST_W-1:0] ST_CHK    = 4'd8;
  localparam logic [ST_W-1:0] ST_START  = 4'd9;
  localparam logic [ST_W-1:0] ST_DONE   = 4'd10;
  localparam logic [ST_W-1:0] ST_ERR    = 4'd11;

  // True for every state that consumes a byte from the stream.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DAT_HI) ||
           (s == ST_DAT_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/pl_byte_timer.sv
// ---------------------------------------------------------------------------
// pl_byte_timer -- inter-byte timeout counter for the program loader.
//
// A loadable down-counter. While en is high and clr is low it counts down
// from LOAD_VAL-1; expired is raised in the LOAD_VAL-th consecutive idle
// cycle so the owner can abort in that same cycle. clr reloads the counter.
// LOAD_VAL = 0 disables the timer entirely (expired never rises).
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   clr     in   reload the counter (byte accepted / not waiting for a byte)
//   en      in   count this cycle (waiting for a byte)
//   expired out  idle limit reached this cycle
// ---------------------------------------------------------------------------
module pl_byte_timer #(
  parameter int unsigned LOAD_VAL = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [31:0] RELOAD = (LOAD_VAL == 0) ? 32'd0 : 32'(LOAD_VAL - 1);
  localparam logic        TMO_ON = (LOAD_VAL != 0);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en && (cnt != 32'd0)) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign expired = TMO_ON && en && !clr && (cnt == 32'd0);

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- upstream program-load stage for the 16-bit multicycle CPU.
//
// Accepts a byte stream from a valid/ready source (UART receiver style),
// packs pairs of bytes (high byte first) into 16-bit words and writes them
// into CPU memory through the CPU test port. After the last word it drops
// test and pulses start for one cycle.
//
// Stream: word count N (2 bytes, high first), N data words (high byte
// first), and, when PROG_LOADER_CHECKSUM_EN is defined, one trailing byte
// equal to the XOR of every header and data byte.
//
// Build option:
//   PROG_LOADER_CHECKSUM_EN  adds the XOR checksum byte and the CHK state.
//
// Parameters:
//   BASE_ADDR    address of the first loaded word
//   MAX_WORDS    largest accepted word count (larger header -> error)
//   TIMEOUT_CYC  idle cycles allowed while waiting for a byte (0 = off)
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   load_req           one-cycle request to begin a load (ignored while busy)
//   rx_data/rx_valid   incoming byte and its qualifier
//   rx_ready           byte accepted this cycle when rx_valid is high
//   test               CPU test-mode select, high for the whole load
//   ext_addr/ext_data  CPU memory write address / data
//   tMemWrite          CPU test-port write strobe
//   start              one-cycle CPU start pulse
//   busy               FSM not in IDLE, DONE or ERR
//   done / err         sticky completion / error flags
//   words_loaded       words written so far
// ---------------------------------------------------------------------------
module prog_loader
  import pl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        test,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_data,
  output logic        tMemWrite,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  state_t              state;
  logic [WORD_W-1:0]   n_words;
  logic [BYTE_W-1:0]   dat_hi;
  logic [WORD_W-1:0]   wl_cnt;
  logic [WORD_W-1:0]   n_next;
  logic [WORD_W-1:0]   wl_next;
  logic                accept;
  logic                tmo;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   csum;
`endif

  assign rx_ready = is_rx_state(state);
  assign accept   = rx_valid && rx_ready;
  assign n_next   = {n_words[WORD_W-1:BYTE_W], rx_data};
  assign wl_next  = wl_cnt + 16'd1;

  // Idle counting runs only while a byte is awaited; any accepted byte or a
  // non-receiving state rearms it.
  pl_byte_timer #(
    .LOAD_VAL (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!rx_ready || accept),
    .en      (rx_ready && !accept),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      n_words  <= '0;
      dat_hi   <= '0;
      wl_cnt   <= '0;
      ext_addr <= BASE_ADDR;
      ext_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (tmo) begin
      state <= ST_ERR;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (load_req) begin
            state  <= ST_HDR_HI;
            wl_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        ST_HDR_HI: begin
          if (accept) begin
            n_words[WORD_W-1:BYTE_W] <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum  <= csum ^ rx_data;
`endif
            state <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (accept) begin
            n_words <= n_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum    <= csum ^ rx_data;
`endif
            if ({16'd0, n_next} > MAX_WORDS) begin
              state <= ST_ERR;
            end else if (n_next == 16'd0) begin
              state <= ST_FIN;
            end else begin
              state <= ST_DAT_HI;
            end
          end
        end
        ST_DAT_HI: begin
          if (accept) begin
            dat_hi <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum   <= csum ^ rx_data;
`endif
            state  <= ST_DAT_LO;
          end
        end
        ST_DAT_LO: begin
          // Address and word are registered here so they are stable for
          // the whole WRITE cycle and the HOLD cycle after it.
          if (accept) begin
            ext_addr <= BASE_ADDR + wl_cnt;
            ext_data <= {dat_hi, rx_data};
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          wl_cnt <= wl_next;
          state  <= (wl_next == n_words) ? ST_FIN : ST_DAT_HI;
        end
        ST_FIN: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state <= ST_CHK;
`else
          state <= ST_START;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            state <= (rx_data == csum) ? ST_START : ST_ERR;
          end
        end
`endif
        ST_START: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and strobes decode straight from the state register, so an
  // asynchronous reset clears them (and drops test) immediately.
  assign busy         = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
  assign test         = busy && (state != ST_START);
  assign tMemWrite    = (state == ST_WRITE);
  assign start        = (state == ST_START);
  assign done         = (state == ST_DONE);
  assign err          = (state == ST_ERR);
  assign words_loaded = wl_cnt;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 256;
  localparam int          TMO  = 16;

  logic        clk;
  logic        rst_n;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        test;
  logic [15:0] ext_addr;
  logic [15:0] ext_data;
  logic        tMemWrite;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  prog_loader #(
    .BASE_ADDR   (BASE),
    .MAX_WORDS   (MAXW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .test         (test),
    .ext_addr     (ext_addr),
    .ext_data     (ext_data),
    .tMemWrite    (tMemWrite),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed memory writes and start pulses.
  logic [31:0] wr_q[$];
  int          starts_total = 0;
  int          wr_base;
  int          st_base;

  always @(negedge clk) begin
    if (tMemWrite) wr_q.push_back({ext_addr, ext_data});
    if (start) starts_total++;
  end

  // Reference stream content.
  logic [15:0] words_q[$];
  logic [7:0]  stream_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream = count (hi, lo), words (hi, lo), optional XOR of everything.
  task automatic build_stream(input logic [15:0] n);
    logic [7:0] x;
    logic [15:0] w;
    stream_q.delete();
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    foreach (words_q[i]) begin
      w = words_q[i];
      stream_q.push_back(w[15:8]);
      stream_q.push_back(w[7:0]);
    end
    x = 8'h00;
    foreach (stream_q[i]) x = x ^ stream_q[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    stream_q.push_back(x);
`endif
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (!got) check("rx_handshake", 32'(got), 32'd1);
  endtask

  task automatic begin_load();
    wr_base = wr_q.size();
    st_base = starts_total;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit pulse_mid);
    for (int i = from; i <= to && i < stream_q.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (pulse_mid && i == 3) begin
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
      end
      send_byte(stream_q[i]);
    end
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check({tag, "_settle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Expected outcome from the stream rules: an oversize count writes
  // nothing; otherwise every word lands at BASE+i, and the load completes
  // unless the checksum byte was wrong.
  task automatic check_result(input string tag, input int n, input bit csum_ok);
    bit          good;
    int          nwr;
    logic [15:0] a;
    good = (n <= MAXW) && csum_ok;
    nwr  = (n <= MAXW) ? n : 0;
    check({tag, "_err"},    32'(err),  32'(!good));
    check({tag, "_done"},   32'(done), 32'(good));
    check({tag, "_test"},   32'(test), 32'd0);
    check({tag, "_starts"}, 32'(starts_total - st_base), 32'(good));
    check({tag, "_wl"},     32'(words_loaded), 32'(nwr));
    check({tag, "_nwr"},    32'(wr_q.size() - wr_base), 32'(nwr));
    for (int i = 0; i < nwr && (wr_base + i) < wr_q.size(); i++) begin
      a = BASE + 16'(i);
      check($sformatf("%s_wr%0d", tag, i), wr_q[wr_base + i], {a, words_q[i]});
    end
  endtask

  task automatic full_load(input string tag, input bit pulse_mid);
    begin_load();
    send_range(0, stream_q.size() - 1, pulse_mid);
    settle(tag);
    check_result(tag, words_q.size(), 1'b1);
  endtask

  initial begin
    rst_n    = 1'b1;
    load_req = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_test",   32'(test),         32'd0);
    check("rst_addr",   32'(ext_addr),     32'(BASE));
    check("rst_data",   32'(ext_data),     32'd0);
    check("rst_wr",     32'(tMemWrite),    32'd0);
    check("rst_start",  32'(start),        32'd0);
    check("rst_busy",   32'(busy),         32'd0);
    check("rst_done",   32'(done),         32'd0);
    check("rst_err",    32'(err),          32'd0);
    check("rst_wl",     32'(words_loaded), 32'd0);
    check("rst_ready",  32'(rx_ready),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two-word load 00 02 12 34 AB CD with write timing.
    words_q = '{16'h1234, 16'hABCD};
    build_stream(16'd2);
    begin_load();
    check("t1_test_up", 32'(test), 32'd1);
    send_range(0, 3, 1'b0);
    check("t1_wr_lat",  32'(tMemWrite), 32'd1);
    check("t1_addr0",   32'(ext_addr),  32'(BASE));
    check("t1_data0",   32'(ext_data),  32'h1234);
    @(negedge clk);
    check("t1_hold_wr",   32'(tMemWrite), 32'd0);
    check("t1_hold_data", 32'(ext_data),  32'h1234);
    send_range(4, stream_q.size() - 1, 1'b0);
    settle("t1");
    check_result("t1", 2, 1'b1);

    // Empty program.
    words_q.delete();
    build_stream(16'd0);
    begin_load();
    send_range(0, 1, 1'b0);
`ifndef PROG_LOADER_CHECKSUM_EN
    check("t2_fin_start", 32'(start), 32'd0);
    @(negedge clk);
    check("t2_start", 32'(start), 32'd1);
    check("t2_start_test", 32'(test), 32'd0);
    @(negedge clk);
    check("t2_done", 32'(done), 32'd1);
`else
    send_range(2, stream_q.size() - 1, 1'b0);
`endif
    settle("t2");
    check_result("t2", 0, 1'b1);

    // Oversize count 257.
    words_q.delete();
    stream_q = '{8'h01, 8'h01};
    begin_load();
    send_range(0, 1, 1'b0);
    check("t3_err_now", 32'(err),  32'd1);
    check("t3_test",    32'(test), 32'd0);
    settle("t3");
    check_result("t3", 257, 1'b1);

    // Recovery after the error.
    rand_words(3);
    build_stream(16'd3);
    full_load("t3r", 1'b0);

    // Stall in the middle of a data word.
    words_q = '{16'h1234};
    build_stream(16'd1);
    begin_load();
    send_range(0, 2, 1'b0);
    repeat (TMO - 2) @(negedge clk);
    check("t4_no_early", 32'(err),  32'd0);
    check("t4_busy",     32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("t4_err",    32'(err),  32'd1);
    check("t4_test",   32'(test), 32'd0);
    check("t4_starts", 32'(starts_total - st_base), 32'd0);
    check("t4_nwr",    32'(wr_q.size() - wr_base), 32'd0);

    // Reset after the first word is written.
    rand_words(2);
    build_stream(16'd2);
    begin_load();
    send_range(0, 3, 1'b0);
    repeat (2) @(negedge clk);
    check("t5_wl1",  32'(words_loaded), 32'd1);
    check("t5_nwr1", 32'(wr_q.size() - wr_base), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_test",  32'(test),         32'd0);
    check("t5_busy",  32'(busy),         32'd0);
    check("t5_addr",  32'(ext_addr),     32'(BASE));
    check("t5_data",  32'(ext_data),     32'd0);
    check("t5_wl",    32'(words_loaded), 32'd0);
    check("t5_ready", 32'(rx_ready),     32'd0);
    check("t5_flags", {29'd0, done, err, start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_load("t5r", 1'b0);

    // Random loads, one with a load_req pulse mid-stream.
    for (int k = 0; k < 5; k++) begin
      rand_words($urandom_range(1, 8));
      build_stream(16'(words_q.size()));
      full_load($sformatf("rnd%0d", k), k == 2);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    words_q = '{16'h1234};
    build_stream(16'd1);
    check("c_sum_byte", 32'(stream_q[4]), 32'h27);
    full_load("c_ok", 1'b0);
    stream_q[4] = 8'h00;
    begin_load();
    send_range(0, 4, 1'b0);
    settle("c_bad");
    check_result("c_bad", 1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream program-load stage for the 16-bit multicycle CPU.
- Takes a byte stream from a UART-RX-style valid/ready source and packs it into 16-bit words.
- Writes the words into CPU memory through the CPU test port (test, ext_addr, ext_data, tMemWrite), then releases test and pulses start to launch execution.

Parameters:
- BASE_ADDR, 16'h0000, memory address of the first loaded word.
- MAX_WORDS, 256, largest accepted word count; a header above this is an error.
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes once a load has begun; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_req  in  1  one-cycle request to begin a load; ignored while busy.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- test  out  1  CPU test-mode select; high for the whole load.
- ext_addr  out  16  CPU memory write address.
- ext_data  out  16  CPU memory write data.
- tMemWrite  out  1  CPU test-port write strobe.
- start  out  1  one-cycle CPU start pulse.
- busy  out  1  high when the FSM is not in IDLE, DONE or ERR.
- done  out  1  sticky load-complete flag.
- err  out  1  sticky error flag.
- words_loaded  out  16  number of words written so far.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE; all outputs are 0 except ext_addr=BASE_ADDR.
- Byte transfer: a byte is taken only on a cycle where rx_valid && rx_ready.
  - rx_ready is high only in HDR_HI, HDR_LO, DAT_HI, DAT_LO and CHK.
- Stream format:
  - Word count N, 16 bits, high byte first.
  - N data words, each high byte first.
  - [checksum byte, only with the optional feature].
- FSM states and transitions:
  - IDLE: on load_req go to HDR_HI; set test=1, clear done, err and words_loaded.
  - DONE and ERR: also return to HDR_HI on load_req, with the same actions.
  - HDR_HI -> HDR_LO: latch N[15:8].
  - HDR_LO: latch N[7:0].
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to FIN.
    - Otherwise: go to DAT_HI.
  - DAT_HI -> DAT_LO: latch the high byte.
  - DAT_LO -> WRITE: latch the low byte.
  - WRITE (1 cycle):
    - Drive ext_addr = BASE_ADDR + words_loaded and ext_data = the assembled word.
    - tMemWrite = 1 for exactly this cycle.
    - Go to HOLD.
  - HOLD (1 cycle):
    - ext_addr and ext_data stay unchanged; tMemWrite = 0.
    - words_loaded increments by 1.
    - If words_loaded == N after the increment, go to FIN; otherwise go to DAT_HI.
  - FIN: go to CHK if the feature is enabled, otherwise go to START.
  - START (1 cycle): test=0, start=1; go to DONE.
  - DONE: done=1, test=0.
  - ERR: err=1, test=0, start is never raised.
- Latency: the first tMemWrite comes 1 cycle after the handshake that accepts the 4th stream byte. start comes 2 cycles after the last HOLD cycle (FIN, then START).
- ext_addr arithmetic is 16-bit and wraps modulo 2^16; no error is raised on wrap.
- Timeout:
  - A counter resets on every accepted byte and whenever the FSM leaves a byte-receiving state.
  - In any rx_ready state with no byte for TIMEOUT_CYC cycles, go to ERR.
- load_req while busy: ignored, with no effect on state or counters.
- Reset mid-load: the FSM returns to IDLE immediately and test drops asynchronously. Partial memory contents are left as they are.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running XOR covers every header and data byte.
  - In CHK the loader accepts one more byte and compares it with the running XOR.
  - Match: go to START. Mismatch: go to ERR, with no start pulse.
- When undefined: there is no CHK state and no XOR register, and FIN goes directly to START.

Decomposition:
- Shared package pl_pkg holds:
  - the state enumeration (IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, HOLD, FIN, CHK, START, DONE, ERR);
  - the byte and word width constants.
- One natural sub-module: pl_byte_timer, a loadable down-counter with a clear input and an expired output, used for the timeout.

Test Plan:
- load_req, then bytes 00 02 12 34 AB CD -> tMemWrite pulses with (ext_addr, ext_data) = (0000, 1234), then (0001, ABCD). words_loaded=2, one start pulse, done=1, test=0.
- Header 00 00 -> no tMemWrite, start pulse 2 cycles after HDR_LO, done=1.
- Header 01 01 (257 > MAX_WORDS) -> err=1, no write, no start, test=0. A new load_req then reloads correctly.
- Stall rx_valid=0 for TIMEOUT_CYC cycles in the middle of DAT_LO (TIMEOUT_CYC=16 in the bench) -> err=1, no start.
- Assert rst_n=0 after one word has been written -> all outputs 0 immediately, ext_addr=BASE_ADDR. Then rerun the full load -> done=1.
- With PROG_LOADER_CHECKSUM_EN: stream 00 01 12 34 then checksum 27 -> start pulse. Same stream with checksum 00 -> err=1, no start.
